// File: rtl/mem_io_bridge_if.sv
// CPU <-> memory/IO bridge bus: the CPU request side plus the memory/IO side of mem_io_bridge.
// The bridge connects through the slave modport, and the CPU/testbench side through the master modport.
interface mem_io_bridge_if #(
    parameter int NUM_IO = 4,
    parameter int IO_W   = 16
);
    logic                   req_valid;
    logic                   mRead;
    logic                   mWrite;
    logic                   ioRead;
    logic                   ioWrite;
    logic [31:0]            addr_in;
    logic [31:0]            r_rdata;
    logic                   io_unsigned;
    logic [31:0]            m_rdata;
    logic [NUM_IO*IO_W-1:0] io_rdata;

    logic                   stall;
    logic                   rdata_valid;
    logic [31:0]            r_wdata;
    logic [31:0]            addr_out;
    logic [31:0]            write_data;
    logic                   mem_we;
    logic [NUM_IO-1:0]      io_cs;
    logic                   io_we;
    logic                   err;

    modport master (
        output req_valid, mRead, mWrite, ioRead, ioWrite, addr_in, r_rdata,
               io_unsigned, m_rdata, io_rdata,
        input  stall, rdata_valid, r_wdata, addr_out, write_data, mem_we,
               io_cs, io_we, err
    );

    modport slave (
        input  req_valid, mRead, mWrite, ioRead, ioWrite, addr_in, r_rdata,
               io_unsigned, m_rdata, io_rdata,
        output stall, rdata_valid, r_wdata, addr_out, write_data, mem_we,
               io_cs, io_we, err
    );
endinterface

// File: rtl/mem_io_bridge.sv
// Sequential memory/IO bridge: one load/store per handshake, stalls the CPU during multi-cycle reads.
// Optional MEMIO_ERR_CNT_EN adds a saturating err_cnt output counting ERR cycles.
module mem_io_bridge #(
    parameter int NUM_IO  = 4,
    parameter int IO_W    = 16,
    parameter int IO_BASE = 6,
    parameter int MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_io_bridge_if.slave bus
`ifdef MEMIO_ERR_CNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);
    localparam int SLOT_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

    typedef enum logic [2:0] {IDLE, WR, MEM_RD, IO_RD, RESP, ERR} state_t;
    state_t state, state_nxt;

    logic [SLOT_W-1:0] slot_q, slot_idx;
    logic              uns_q, io_q, rd_q;
    logic [1:0]        lat_cnt;
    logic              accept, multi, in_range, illegal, is_wr, is_rd, lat_done;
    logic [3:0]        nib;
    logic [IO_W-1:0]   slot_data [NUM_IO];
    logic [IO_W-1:0]   io_sel;
    logic [31:0]       io_ext;
    logic [NUM_IO-1:0] cs_dec;

    // Decode of the incoming request; only meaningful while IDLE.
    assign nib      = bus.addr_in[7:4];
    assign slot_idx = SLOT_W'(nib - 4'(IO_BASE));
    assign in_range = (int'(nib) >= IO_BASE) && (int'(nib) < IO_BASE + NUM_IO);
    assign multi    = $countones({bus.mRead, bus.mWrite, bus.ioRead, bus.ioWrite}) > 1;
    assign accept   = bus.req_valid && !rst &&
                      (bus.mRead || bus.mWrite || bus.ioRead || bus.ioWrite);
    assign illegal  = multi || ((bus.ioRead || bus.ioWrite) && !in_range);
    assign is_wr    = bus.mWrite || bus.ioWrite;
    assign is_rd    = bus.mRead || bus.ioRead;
    assign lat_done = (lat_cnt == 2'(MEM_LAT - 1));

    for (genvar k = 0; k < NUM_IO; k++) begin : g_slot
        assign slot_data[k] = bus.io_rdata[k*IO_W +: IO_W];
    end

    assign io_sel = slot_data[slot_q];

    if (IO_W == 32) begin : g_noext
        assign io_ext = io_sel;
    end else begin : g_ext
        assign io_ext = uns_q ? {{(32-IO_W){1'b0}}, io_sel}
                              : {{(32-IO_W){io_sel[IO_W-1]}}, io_sel};
    end

    always_comb begin
        for (int k = 0; k < NUM_IO; k++)
            cs_dec[k] = (slot_q == SLOT_W'(k));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal)         state_nxt = ERR;
                    else if (is_wr)      state_nxt = WR;
                    else if (bus.mRead)  state_nxt = MEM_RD;
                    else                 state_nxt = IO_RD;
                end
            end
            MEM_RD:  if (lat_done) state_nxt = RESP;
            IO_RD:   state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and status decode from state and registered request fields only.
    always_comb begin
        bus.stall       = 1'b0;
        bus.mem_we      = 1'b0;
        bus.io_we       = 1'b0;
        bus.io_cs       = '0;
        bus.err         = 1'b0;
        bus.rdata_valid = 1'b0;
        case (state)
            IDLE:   bus.stall = accept;
            WR: begin
                bus.mem_we = !io_q;
                bus.io_we  = io_q;
                if (io_q) bus.io_cs = cs_dec;
            end
            MEM_RD: bus.stall = 1'b1;
            IO_RD: begin
                bus.stall = 1'b1;
                bus.io_cs = cs_dec;
            end
            RESP:   bus.rdata_valid = 1'b1;
            ERR: begin
                bus.err         = 1'b1;
                bus.rdata_valid = rd_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.addr_out   <= '0;
            bus.write_data <= '0;
            bus.r_wdata    <= '0;
            slot_q         <= '0;
            uns_q          <= 1'b0;
            io_q           <= 1'b0;
            rd_q           <= 1'b0;
            lat_cnt        <= '0;
        end else if (state == IDLE && accept) begin
            bus.addr_out   <= bus.addr_in;
            bus.write_data <= bus.r_rdata;
            slot_q         <= slot_idx;
            uns_q          <= bus.io_unsigned;
            io_q           <= bus.ioRead || bus.ioWrite;
            rd_q           <= is_rd;
            lat_cnt        <= '0;
            // A rejected read answers with zero data during ERR.
            if (illegal && is_rd) bus.r_wdata <= '0;
        end else if (state == MEM_RD) begin
            if (lat_done) bus.r_wdata <= bus.m_rdata;
            else          lat_cnt     <= lat_cnt + 2'd1;
        end else if (state == IO_RD) begin
            bus.r_wdata <= io_ext;
        end
    end

`ifdef MEMIO_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 err_cnt <= '0;
        else if (state == ERR && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif
endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Parametrised, sequential successor to the CPU's combinational memory/IO split.
- Accepts one load/store per handshake from the CPU datapath and routes it to data memory or to one of NUM_IO memory-mapped IO slots.
- Holds the CPU with `stall` while a multi-cycle memory or IO read completes, then returns a single-cycle valid response.
- Sits between ALU/controller/decoder and data memory plus IO peripherals (LED, switch, segment and others).

Parameters:
- NUM_IO, 4: number of IO slots, 1..8.
- IO_W, 16: data width of each IO read channel, 1..32.
- IO_BASE, 6: slot k is selected when addr[7:4] == IO_BASE+k; IO_BASE+NUM_IO must be <= 16.
- MEM_LAT, 1: data-memory read latency in cycles, 1..4.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU presents an access this cycle.
- mRead, mWrite, ioRead, ioWrite  in  1 each  access type from the controller.
- addr_in  in  32  byte address (ALU result).
- r_rdata  in  32  store data from the register file.
- io_unsigned  in  1  zero-extend IO read data when 1, sign-extend when 0.
- m_rdata  in  32  data-memory read data.
- io_rdata  in  NUM_IO*IO_W  IO read data; slot k is at [k*IO_W +: IO_W].
- stall  out  1  CPU must hold its request and the pipeline.
- rdata_valid  out  1  r_wdata is valid this cycle.
- r_wdata  out  32  load result to the register file.
- addr_out  out  32  registered address to memory and IO.
- write_data  out  32  registered store data.
- mem_we  out  1  data-memory write strobe.
- io_cs  out  NUM_IO  one-hot IO slot select.
- io_we  out  1  IO write strobe, qualified by io_cs.
- err  out  1  one-cycle pulse marking an illegal access.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0: addr_out, write_data, r_wdata, io_cs, strobes, stall, rdata_valid, err. write_data is never Z.
- Legal request: req_valid=1 with exactly one of mRead/mWrite/ioRead/ioWrite set.
  - Illegal decodes: more than one control bit set; or an IO access whose slot index addr[7:4]-IO_BASE is outside 0..NUM_IO-1.
  - req_valid=1 with no control bit set is ignored: stall=0 and state stays IDLE.
- IDLE, legal or illegal request:
  - Register addr_in→addr_out, r_rdata→write_data, slot index, io_unsigned.
  - stall=1 combinationally in this cycle.
  - Next state: WR for writes, MEM_RD for mRead, IO_RD for ioRead, ERR for illegal.
- WR (1 cycle):
  - mem_we=1, or io_we=1 with io_cs one-hot on the slot.
  - stall=0, then IDLE.
  - Total write latency is 2 cycles.
- MEM_RD:
  - A counter runs MEM_LAT cycles with stall=1.
  - m_rdata is captured at the end of the last cycle, then RESP.
- IO_RD (1 cycle):
  - io_cs asserted, stall=1.
  - The slot's IO_W bits are captured and extended to 32 bits (zero or sign per the registered io_unsigned), then RESP.
  - If IO_W=32, no extension is applied.
- RESP (1 cycle): rdata_valid=1, stall=0, r_wdata holds the captured data, then IDLE.
  - r_wdata keeps its value until the next RESP.
  - A new request is only accepted in IDLE, so back-to-back accesses are spaced by at least one IDLE cycle.
- ERR (1 cycle): err=1, rdata_valid=1 for reads with r_wdata=0, no strobes, stall=0, then IDLE.
- Inputs are ignored outside IDLE; the CPU holds them stable while stall=1.
- Reset mid-read: the response is dropped and no strobe or rdata_valid is emitted afterwards.

Optional Feature:
- Macro MEMIO_ERR_CNT_EN.
- Defined: adds output err_cnt [7:0], which increments on every ERR cycle, saturates at 255, and clears only on rst.
- Undefined: no port and no counter logic; err behaviour is unchanged.

Test Plan:
- mWrite, addr 0x0000_0040, data 0xDEAD_BEEF → next cycle mem_we=1, addr_out=0x40, write_data=0xDEADBEEF, stall 1 then 0, io_cs=0.
- MEM_LAT=2, mRead addr 0x10, m_rdata=0x1234_5678 → stall=1 for 3 cycles, then rdata_valid=1 and r_wdata=0x12345678 for exactly 1 cycle.
- ioRead addr 0x70 (slot 1), io_rdata slot1=16'h8001:
  - io_unsigned=0 → r_wdata=0xFFFF8001.
  - io_unsigned=1 → r_wdata=0x00008001.
  - io_cs=4'b0010 during IO_RD.
- ioWrite addr 0x60, data 0x5 → io_we=1, io_cs=4'b0001 for 1 cycle, mem_we=0.
- ioRead addr 0xB0 (slot 5, NUM_IO=4), and separately mRead+mWrite together → err pulse, r_wdata=0 with rdata_valid for the read, no strobes; err_cnt=2 with MEMIO_ERR_CNT_EN.
- rst asserted during MEM_RD → all outputs 0 immediately; no rdata_valid after release; the next mRead completes normally.
